// File: rtl/tx_pkt_serializer_pkg.sv
// Shared types, packet-type constants and helper functions for the TX packet serializer.
package tx_pkt_pkg;

  localparam int WORD_W     = 16;
  localparam int NUM_FIELDS = 7;

  localparam logic [2:0] PKT_HB      = 3'b000;
  localparam logic [2:0] PKT_CHE     = 3'b001;
  localparam logic [2:0] PKT_INV     = 3'b010;
  localparam logic [2:0] PKT_MR      = 3'b011;
  localparam logic [2:0] PKT_CHT     = 3'b100;
  localparam logic [2:0] PKT_DATA    = 3'b101;
  localparam logic [2:0] PKT_SOS     = 3'b110;
  localparam logic [2:0] PKT_INVALID = 3'b111;

  localparam int FIELD_SRC       = 0;
  localparam int FIELD_DEST      = 1;
  localparam int FIELD_SRC_HOPS  = 2;
  localparam int FIELD_QVALUE    = 3;
  localparam int FIELD_ENERGY    = 4;
  localparam int FIELD_CHOSEN_CH = 5;
  localparam int FIELD_HOPS_CH   = 6;

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_BODY, S_CSUM} tx_state_t;

  typedef struct packed {
    logic                                valid;
    logic [2:0]                          ptype;
    logic [NUM_FIELDS-1:0][WORD_W-1:0]   fields;
  } pkt_slot_t;

  // An all-zero mask marks a packet type that is never transmitted.
  function automatic logic [NUM_FIELDS-1:0] type_mask(input logic [2:0] ptype);
    case (ptype)
      PKT_HB:                 return 7'b0011101;
      PKT_INV:                return 7'b1111001;
      PKT_MR:                 return 7'b0011111;
      PKT_CHT:                return 7'b0100011;
      PKT_DATA, PKT_SOS:      return 7'b0011111;
      PKT_CHE, PKT_INVALID:   return 7'b0000000;
      default:                return 7'b0000000;
    endcase
  endfunction

  function automatic logic [7:0] pkt_len(input logic [NUM_FIELDS-1:0] mask);
    logic [7:0] n;
    n = 8'd2;
    for (int i = 0; i < NUM_FIELDS; i++) n = n + {7'b0, mask[i]};
    return n;
  endfunction

  function automatic logic [2:0] first_set(input logic [NUM_FIELDS-1:0] mask);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = NUM_FIELDS - 1; i >= 0; i--) if (mask[i]) idx = 3'(i);
    return idx;
  endfunction

endpackage

// File: rtl/tx_pkt_serializer_if.sv
// Word stream from the serializer to the MAC: data/valid/last forward, ready back.
interface tx_pkt_serializer_if #(parameter int WORD_WIDTH = 16) ();

  logic [WORD_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_last;
  logic                  tx_ready;

  modport master (output tx_data, tx_valid, tx_last, input tx_ready);
  modport slave  (input tx_data, tx_valid, tx_last, output tx_ready);

endinterface

// File: rtl/tx_pkt_slot_buf.sv
// Two-entry packet store: the active slot feeds the serializer, the hold slot queues one more.
module tx_pkt_slot_buf import tx_pkt_pkg::*; #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 load,
  input  logic                 advance,
  input  pkt_slot_t            new_pkt,
  output pkt_slot_t            active,
  output logic                 hold_valid,
  output logic                 load_active,
  output logic [CNT_WIDTH-1:0] drop_cnt
);

  pkt_slot_t hold;
  logic      load_hold;
  logic      drop;

  // A checksum transfer frees a slot this cycle, so a coinciding load is never dropped.
  always_comb begin
    load_active = load && (!active.valid || (advance && !hold.valid));
    load_hold   = load && !load_active && (!hold.valid || advance);
    drop        = load && !load_active && !load_hold;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      active   <= '0;
      hold     <= '0;
      drop_cnt <= '0;
    end else begin
      if (load_active)  active <= new_pkt;
      else if (advance) active <= hold;

      if (load_hold)    hold <= new_pkt;
      else if (advance) hold.valid <= 1'b0;

      if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + CNT_WIDTH'(1);
    end
  end

  assign hold_valid = hold.valid;

endmodule

// File: rtl/tx_pkt_serializer.sv
// Serializes captured reward packets into header / masked fields / XOR checksum words for the MAC.
module tx_pkt_serializer import tx_pkt_pkg::*; #(
  parameter int WORD_WIDTH = WORD_W,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  reward_done,
  input  logic [2:0]            rPacketType,
  input  logic [WORD_WIDTH-1:0] rSourceID,
  input  logic [WORD_WIDTH-1:0] rDestinationID,
  input  logic [WORD_WIDTH-1:0] rSourceHops,
  input  logic [WORD_WIDTH-1:0] rQValue,
  input  logic [WORD_WIDTH-1:0] rEnergyLeft,
  input  logic [WORD_WIDTH-1:0] rChosenCH,
  input  logic [WORD_WIDTH-1:0] rHopsFromCH,
  tx_pkt_serializer_if.master   tx,
  output logic                  busy,
  output logic                  pkt_sent,
  output logic [CNT_WIDTH-1:0]  drop_cnt
);

  tx_state_t                 state, next_state;
  pkt_slot_t                 new_pkt, active;
  logic                      hold_valid, load_active, load, xfer, advance;
  logic [NUM_FIELDS-1:0]     active_mask, rem_mask, rem_next;
  logic [2:0]                field_idx;
  logic [WORD_W-1:0]         header, csum;

  always_comb begin
    new_pkt                          = '0;
    new_pkt.valid                    = 1'b1;
    new_pkt.ptype                    = rPacketType;
    new_pkt.fields[FIELD_SRC]        = rSourceID;
    new_pkt.fields[FIELD_DEST]       = rDestinationID;
    new_pkt.fields[FIELD_SRC_HOPS]   = rSourceHops;
    new_pkt.fields[FIELD_QVALUE]     = rQValue;
    new_pkt.fields[FIELD_ENERGY]     = rEnergyLeft;
    new_pkt.fields[FIELD_CHOSEN_CH]  = rChosenCH;
    new_pkt.fields[FIELD_HOPS_CH]    = rHopsFromCH;
  end

  assign load        = reward_done && (type_mask(rPacketType) != '0);
  assign xfer        = (state != S_IDLE) && tx.tx_ready;
  assign advance     = (state == S_CSUM) && tx.tx_ready;
  assign active_mask = type_mask(active.ptype);
  assign header      = {5'b0, active.ptype, pkt_len(active_mask)};
  assign rem_next    = rem_mask & ~(7'(1) << field_idx);
  assign busy        = active.valid || hold_valid;

  tx_pkt_slot_buf #(.CNT_WIDTH(CNT_WIDTH)) u_slot_buf (
    .clk         (clk),
    .nrst        (nrst),
    .load        (load),
    .advance     (advance),
    .new_pkt     (new_pkt),
    .active      (active),
    .hold_valid  (hold_valid),
    .load_active (load_active),
    .drop_cnt    (drop_cnt)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= S_IDLE;
    else       state <= next_state;
  end

  // Outputs come only from registers, so they stay stable while the MAC stalls.
  always_comb begin
    next_state  = state;
    tx.tx_valid = 1'b0;
    tx.tx_last  = 1'b0;
    tx.tx_data  = '0;
    pkt_sent    = 1'b0;
    case (state)
      S_IDLE: if (load_active) next_state = S_HDR;
      S_HDR: begin
        tx.tx_valid = 1'b1;
        tx.tx_data  = header;
        if (xfer) next_state = S_BODY;
      end
      S_BODY: begin
        tx.tx_valid = 1'b1;
        tx.tx_data  = active.fields[field_idx];
        if (xfer && (rem_next == '0)) next_state = S_CSUM;
      end
      S_CSUM: begin
        tx.tx_valid = 1'b1;
        tx.tx_last  = 1'b1;
        tx.tx_data  = csum;
        if (xfer) begin
          pkt_sent   = 1'b1;
          next_state = (hold_valid || load_active) ? S_HDR : S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      field_idx <= '0;
      rem_mask  <= '0;
      csum      <= '0;
    end else if (xfer) begin
      case (state)
        S_HDR: begin
          csum      <= header;
          rem_mask  <= active_mask;
          field_idx <= first_set(active_mask);
        end
        S_BODY: begin
          csum      <= csum ^ active.fields[field_idx];
          rem_mask  <= rem_next;
          field_idx <= first_set(rem_next);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_pkt_serializer.sv
// Directed self-checking bench for tx_pkt_serializer with hand-computed word streams.
module tb_tx_pkt_serializer;
  import tx_pkt_pkg::*;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        reward_done = 1'b0;
  logic [2:0]  rPacketType = '0;
  logic [15:0] rSourceID = '0, rDestinationID = '0, rSourceHops = '0, rQValue = '0;
  logic [15:0] rEnergyLeft = '0, rChosenCH = '0, rHopsFromCH = '0;
  logic        busy, pkt_sent;
  logic [7:0]  drop_cnt;

  tx_pkt_serializer_if #(.WORD_WIDTH(16)) tx_if ();

  tx_pkt_serializer #(.WORD_WIDTH(16), .CNT_WIDTH(8)) dut (
    .clk(clk), .nrst(nrst), .reward_done(reward_done), .rPacketType(rPacketType),
    .rSourceID(rSourceID), .rDestinationID(rDestinationID), .rSourceHops(rSourceHops),
    .rQValue(rQValue), .rEnergyLeft(rEnergyLeft), .rChosenCH(rChosenCH),
    .rHopsFromCH(rHopsFromCH), .tx(tx_if), .busy(busy), .pkt_sent(pkt_sent),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int          compared = 0;
  int          mismatched = 0;
  logic [15:0] exp_words [0:15];
  logic        exp_last  [0:15];
  int          exp_n = 0;
  int          stall_idx = -1;
  int          stall_len = 0;
  logic [6:0][15:0] hb1, hb2, dat_a, dat_b, dat_c, inv1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0][15:0] mkFields(input logic [15:0] a, b, c, d, e, f, g);
    return {g, f, e, d, c, b, a};
  endfunction

  task automatic driveFields(input logic [2:0] t, input logic [6:0][15:0] f);
    rPacketType = t;
    rSourceID = f[0]; rDestinationID = f[1]; rSourceHops = f[2]; rQValue = f[3];
    rEnergyLeft = f[4]; rChosenCH = f[5]; rHopsFromCH = f[6];
    reward_done = 1'b1;
  endtask

  task automatic applyStimulus(input logic [2:0] t, input logic [6:0][15:0] f);
    @(negedge clk);
    driveFields(t, f);
    @(negedge clk);
    reward_done = 1'b0;
  endtask

  task automatic pushWord(input logic [15:0] w, input logic last);
    exp_words[exp_n] = w;
    exp_last[exp_n]  = last;
    exp_n++;
  endtask

  task automatic expectHb1();
    exp_n = 0;
    pushWord(16'h0006, 0); pushWord(16'h0003, 0); pushWord(16'h0002, 0);
    pushWord(16'h0064, 0); pushWord(16'h03E8, 0); pushWord(16'h038B, 1);
  endtask

  // Starts in the current cycle; optionally holds ready low for stall_len cycles on word stall_idx.
  task automatic collectPacket(input string tag, input int n);
    int  idx = 0;
    int  gaps = 0;
    int  budget = 0;
    int  stall_left = stall_len;
    bit  started = 0;
    while (idx < n && budget < 300) begin
      tx_if.tx_ready = !(tx_if.tx_valid && idx == stall_idx && stall_left > 0);
      #1;
      if (!tx_if.tx_ready) begin
        checkOutput($sformatf("%s_stall_data", tag), tx_if.tx_data, exp_words[idx]);
        checkOutput($sformatf("%s_stall_valid", tag), tx_if.tx_valid, 1);
        stall_left--;
      end else if (tx_if.tx_valid) begin
        started = 1;
        checkOutput($sformatf("%s_w%0d_data", tag, idx), tx_if.tx_data, exp_words[idx]);
        checkOutput($sformatf("%s_w%0d_last", tag, idx), tx_if.tx_last, exp_last[idx]);
        checkOutput($sformatf("%s_w%0d_sent", tag, idx), pkt_sent, exp_last[idx]);
        idx++;
      end else if (started) begin
        gaps++;
      end
      budget++;
      if (idx < n) @(negedge clk);
    end
    checkOutput($sformatf("%s_count", tag), idx, n);
    checkOutput($sformatf("%s_gaps", tag), gaps, 0);
    tx_if.tx_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int b;
    hb1   = mkFields(16'h0003, 16'h7777, 16'h0002, 16'h0064, 16'h03E8, 16'h5555, 16'h6666);
    hb2   = mkFields(16'h00F0, 16'h1111, 16'h000F, 16'h1234, 16'h4321, 16'h2222, 16'h3333);
    dat_a = mkFields(16'h0001, 16'h0002, 16'h0004, 16'h0008, 16'h0010, 16'hDEAD, 16'hBEEF);
    dat_b = mkFields(16'h0100, 16'h0200, 16'h0400, 16'h0800, 16'h1000, 16'hDEAD, 16'hBEEF);
    dat_c = mkFields(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    inv1  = mkFields(16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D, 16'h0E0E, 16'h0F0F, 16'h1010);
    tx_if.tx_ready = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_data", tx_if.tx_data, 0);
    checkOutput("rst_valid", tx_if.tx_valid, 0);
    checkOutput("rst_last", tx_if.tx_last, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_sent", pkt_sent, 0);
    checkOutput("rst_drop", drop_cnt, 0);
    @(negedge clk);
    nrst = 1'b1;

    $display("[TB] non-transmit types");
    tx_if.tx_ready = 1'b1;
    applyStimulus(PKT_CHE, hb1);
    repeat (2) @(negedge clk);
    #1;
    checkOutput("che_valid", tx_if.tx_valid, 0);
    checkOutput("che_busy", busy, 0);
    checkOutput("che_drop", drop_cnt, 0);
    applyStimulus(PKT_INVALID, hb1);
    repeat (2) @(negedge clk);
    #1;
    checkOutput("t111_valid", tx_if.tx_valid, 0);
    checkOutput("t111_busy", busy, 0);
    checkOutput("t111_drop", drop_cnt, 0);

    $display("[TB] HB stream");
    expectHb1();
    applyStimulus(PKT_HB, hb1);
    collectPacket("hb", 6);
    @(negedge clk);
    #1;
    checkOutput("hb_idle_valid", tx_if.tx_valid, 0);
    checkOutput("hb_idle_busy", busy, 0);
    checkOutput("hb_idle_sent", pkt_sent, 0);

    $display("[TB] HB stream with stall");
    stall_idx = 2;
    stall_len = 3;
    applyStimulus(PKT_HB, hb1);
    collectPacket("hb_stall", 6);
    stall_idx = -1;
    stall_len = 0;

    $display("[TB] back-to-back DATA with drop");
    @(negedge clk);
    tx_if.tx_ready = 1'b0;
    driveFields(PKT_DATA, dat_a);
    @(negedge clk);
    driveFields(PKT_DATA, dat_b);
    @(negedge clk);
    driveFields(PKT_DATA, dat_c);
    @(negedge clk);
    reward_done = 1'b0;
    #1;
    checkOutput("b2b_drop", drop_cnt, 1);
    checkOutput("b2b_busy", busy, 1);
    exp_n = 0;
    pushWord(16'h0507, 0); pushWord(16'h0001, 0); pushWord(16'h0002, 0); pushWord(16'h0004, 0);
    pushWord(16'h0008, 0); pushWord(16'h0010, 0); pushWord(16'h0518, 1);
    pushWord(16'h0507, 0); pushWord(16'h0100, 0); pushWord(16'h0200, 0); pushWord(16'h0400, 0);
    pushWord(16'h0800, 0); pushWord(16'h1000, 0); pushWord(16'h1A07, 1);
    collectPacket("b2b", 14);

    $display("[TB] strobe on checksum transfer");
    @(negedge clk);
    tx_if.tx_ready = 1'b1;
    applyStimulus(PKT_HB, hb1);
    repeat (5) @(negedge clk);
    driveFields(PKT_HB, hb2);
    #1;
    checkOutput("co_last", tx_if.tx_last, 1);
    checkOutput("co_csum", tx_if.tx_data, 16'h038B);
    checkOutput("co_sent", pkt_sent, 1);
    @(negedge clk);
    reward_done = 1'b0;
    #1;
    checkOutput("co_next_valid", tx_if.tx_valid, 1);
    checkOutput("co_drop", drop_cnt, 1);
    exp_n = 0;
    pushWord(16'h0006, 0); pushWord(16'h00F0, 0); pushWord(16'h000F, 0);
    pushWord(16'h1234, 0); pushWord(16'h4321, 0); pushWord(16'h51EC, 1);
    collectPacket("co", 6);

    $display("[TB] drop counter saturation");
    @(negedge clk);
    tx_if.tx_ready = 1'b0;
    driveFields(PKT_DATA, dat_a);
    repeat (260) @(negedge clk);
    reward_done = 1'b0;
    #1;
    checkOutput("sat_drop", drop_cnt, 8'hFF);
    checkOutput("sat_busy", busy, 1);
    tx_if.tx_ready = 1'b1;
    b = 0;
    while (busy && b < 100) begin
      @(negedge clk);
      b++;
    end
    #1;
    checkOutput("drain_idle", busy, 0);

    $display("[TB] reset during INV body");
    applyStimulus(PKT_INV, inv1);
    #1;
    checkOutput("inv_hdr", tx_if.tx_data, 16'h0207);
    repeat (2) @(negedge clk);
    #1;
    checkOutput("inv_body_data", tx_if.tx_data, 16'h0D0D);
    nrst = 1'b0;
    #1;
    checkOutput("mid_rst_valid", tx_if.tx_valid, 0);
    checkOutput("mid_rst_data", tx_if.tx_data, 0);
    checkOutput("mid_rst_last", tx_if.tx_last, 0);
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_drop", drop_cnt, 0);
    @(negedge clk);
    nrst = 1'b1;
    expectHb1();
    applyStimulus(PKT_HB, hb1);
    collectPacket("post_rst", 6);
    @(negedge clk);
    #1;
    checkOutput("post_rst_idle", tx_if.tx_valid, 0);
    checkOutput("post_rst_drop", drop_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
